hex_keypad_scanner: RTL and testbench
=====================================

// Module: hex_keypad_scanner
// PURPOSE
//  Reads a 4x4 hex matrix keypad (Pmod KYPD layout), the input counterpart of the multiplexed 7-seg driver.
//  Drives one column low at a time, samples the rows, debounces over whole scan frames.
//  Emits a 1-cycle key_valid pulse with the 4-bit hex code per accepted press; feeds ALU operand entry.
// PARAMETERS
//  SCAN_BITS      18  log2 of cycles per column slot; frame = 4*2^SCAN_BITS cycles; legal >= 2
//  DEBOUNCE_SCANS 4   consecutive identical frames needed to accept a press or a release; legal 1..15
// PORTS
//  clk        in   1  system clock; all logic on rising edge
//  reset_n    in   1  asynchronous, active-low reset
//  row        in   4  keypad rows, active-low (pulled up), asynchronous to clk
//  col        out  4  keypad columns, active-low, exactly one bit low at all times
//  key_code   out  4  hex code of last accepted key; held until next accepted press
//  key_valid  out  1  1-cycle pulse when a new key is accepted
//  key_held   out  1  high from acceptance until release is debounced
// BEHAVIOUR
//  Reset (async, reset_n=0): scan counter 0, col=4'b1110, row synchronizer=4'b1111, state IDLE.
//   Also debounce count 0, key_code=0, key_valid=0, key_held=0.
//  Scan: free-running SCAN_BITS+2 counter; top 2 bits = active column c; col = ~(4'b0001<<c); wraps 3->0.
//  row passes through 2-flop synchronizer; sampled on the LAST cycle of each column slot (settle time).
//  Key map [col][row0..3]: c0:1,4,7,0  c1:2,5,8,F  c2:3,6,9,E  c3:A,B,C,D.
//  Frame accumulator over the 4 slots: hits saturate at 2, plus code of first hit.
//   Frame result = NONE (0 hits), SINGLE(code) (1 hit), MULTI (>=2 hits, incl. 2 rows in one slot).
//  Result evaluated on last cycle of col-3 slot; accumulator clears for next frame same edge.
//  FSM advances once per frame end; cnt = debounce count; cand = candidate code:
//   IDLE:     SINGLE(k) -> DEBOUNCE, cand=k, cnt=1 (if DEBOUNCE_SCANS=1 go PRESSED directly); else stay.
//   DEBOUNCE: SINGLE(cand) -> cnt+1; at cnt==DEBOUNCE_SCANS -> PRESSED.
//             SINGLE(k!=cand) -> cand=k, cnt=1; NONE or MULTI -> IDLE.
//   PRESSED:  NONE -> RELEASE, cnt=1 (DEBOUNCE_SCANS=1: straight to IDLE); SINGLE/MULTI -> stay.
//             Rollover/second key ignored; no new pulse.
//   RELEASE:  NONE -> cnt+1; at cnt==DEBOUNCE_SCANS -> IDLE. Any SINGLE/MULTI -> PRESSED, cnt=0, no pulse.
//  On entry to PRESSED from DEBOUNCE/IDLE: key_code<=cand, key_valid=1 next cycle only.
//   Latency: pulse 1 cycle after end of DEBOUNCE_SCANS-th matching frame.
//  key_held=1 in PRESSED and RELEASE, 0 in IDLE/DEBOUNCE; registered, same edge as key_valid.
//  A press already in progress at reset is re-debounced from IDLE; partial frame at reset is discarded.
//  Pulse min spacing: 2*DEBOUNCE_SCANS frames.
//  All outputs registered; no combinational path from row to outputs.
// TESTING (SCAN_BITS=2 -> 4-cycle slot, 16-cycle frame; DEBOUNCE_SCANS=3)
//  1 Reset/scan: reset_n=0 mid-run -> col=1110, key_*=0 immediately.
//    After release: col 1110,1101,1011,0111 each 4 cycles, wraps.
//  2 Press '5' (row1 low while col1 low) steady -> one key_valid, key_code=5, at end of frame 3 +1 cycle.
//    key_held=1; release -> key_held=0 after 3 empty frames.
//  3 Bounce '9': present 2 frames, absent 1, present 4 -> exactly one pulse, key_code=9, 3 frames after re-press.
//  4 Ghost: '1' and '2' together 6 frames -> no pulse; key_code keeps old value, key_held=0.
//  5 Rollover: hold 'D', accepted; add 'A' for 5 frames -> no second pulse, key_code=D.
//    Release-glitch 1 empty frame in RELEASE -> stays held.
//  6 Corners '0' (c0,r3) and 'F' (c1,r3) pressed in turn with full release -> codes 0 then F.
//    Exactly one pulse per press.

Source files
------------

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex matrix keypad scanner: column strobing, row synchronisation,
// frame-based hit accumulation and a debounce FSM emitting one pulse per press.
module hex_keypad_scanner #(
  parameter int SCAN_BITS      = 18,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CW = SCAN_BITS + 2;
  localparam logic [3:0] DS = 4'(DEBOUNCE_SCANS);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_PRESSED  = 2'd2;
  localparam logic [1:0] S_RELEASE  = 2'd3;

  logic [CW-1:0] scanCnt_q, scanCnt_d;
  logic [3:0]    col_q;
  logic [3:0]    rowMeta_q, rowSync_q;
  logic [1:0]    hits_q, hits_d;
  logic [3:0]    firstCode_q, firstCode_d;
  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    keyCode_q, keyCode_d;
  logic          keyValid_q, keyValid_d;
  logic          keyHeld_q, keyHeld_d;

  logic [1:0] colSel;
  logic       slotLast, frameEnd;
  logic [2:0] slotHits, hitSum;
  logic [3:0] slotCode;
  logic [1:0] frameHits;
  logic [3:0] frameCode;
  logic [3:0] cntInc;

  function automatic logic [3:0] keyMap(input logic [1:0] c, input logic [1:0] r);
    case ({c, r})
      4'b0000: keyMap = 4'h1;
      4'b0001: keyMap = 4'h4;
      4'b0010: keyMap = 4'h7;
      4'b0011: keyMap = 4'h0;
      4'b0100: keyMap = 4'h2;
      4'b0101: keyMap = 4'h5;
      4'b0110: keyMap = 4'h8;
      4'b0111: keyMap = 4'hF;
      4'b1000: keyMap = 4'h3;
      4'b1001: keyMap = 4'h6;
      4'b1010: keyMap = 4'h9;
      4'b1011: keyMap = 4'hE;
      4'b1100: keyMap = 4'hA;
      4'b1101: keyMap = 4'hB;
      4'b1110: keyMap = 4'hC;
      default: keyMap = 4'hD;
    endcase
  endfunction

  assign colSel    = scanCnt_q[CW-1 -: 2];
  assign slotLast  = &scanCnt_q[SCAN_BITS-1:0];
  assign frameEnd  = slotLast && (colSel == 2'd3);
  assign scanCnt_d = scanCnt_q + 1'b1;
  assign cntInc    = cnt_q + 4'd1;

  // Rows are sampled late in each slot so two sync stages see settled values.
  always_comb begin
    slotHits = 3'd0;
    slotCode = 4'h0;
    for (int r = 3; r >= 0; r--) begin
      if (!rowSync_q[r]) begin
        slotHits = slotHits + 3'd1;
        slotCode = keyMap(colSel, 2'(r));
      end
    end
    hitSum    = {1'b0, hits_q} + slotHits;
    frameHits = (hitSum >= 3'd2) ? 2'd2 : hitSum[1:0];
    frameCode = (hits_q == 2'd0) ? slotCode : firstCode_q;
    hits_d      = hits_q;
    firstCode_d = firstCode_q;
    if (slotLast) begin
      hits_d      = frameEnd ? 2'd0 : frameHits;
      firstCode_d = frameEnd ? 4'h0 : frameCode;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cand_d     = cand_q;
    keyCode_d  = keyCode_q;
    keyValid_d = 1'b0;
    if (frameEnd) begin
      case (state_q)
        S_IDLE: begin
          if (frameHits == 2'd1) begin
            cand_d = frameCode;
            cnt_d  = 4'd1;
            if (DEBOUNCE_SCANS == 1) begin
              state_d    = S_PRESSED;
              keyCode_d  = frameCode;
              keyValid_d = 1'b1;
            end else begin
              state_d = S_DEBOUNCE;
            end
          end
        end
        S_DEBOUNCE: begin
          if (frameHits == 2'd1 && frameCode == cand_q) begin
            cnt_d = cntInc;
            if (cntInc == DS) begin
              state_d    = S_PRESSED;
              keyCode_d  = cand_q;
              keyValid_d = 1'b1;
            end
          end else if (frameHits == 2'd1) begin
            cand_d = frameCode;
            cnt_d  = 4'd1;
          end else begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
          end
        end
        S_PRESSED: begin
          if (frameHits == 2'd0) begin
            cnt_d   = (DEBOUNCE_SCANS == 1) ? 4'd0 : 4'd1;
            state_d = (DEBOUNCE_SCANS == 1) ? S_IDLE : S_RELEASE;
          end
        end
        default: begin
          if (frameHits == 2'd0) begin
            cnt_d = cntInc;
            if (cntInc == DS) begin
              state_d = S_IDLE;
              cnt_d   = 4'd0;
            end
          end else begin
            state_d = S_PRESSED;
            cnt_d   = 4'd0;
          end
        end
      endcase
    end
    keyHeld_d = (state_d == S_PRESSED) || (state_d == S_RELEASE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scanCnt_q   <= '0;
      col_q       <= 4'b1110;
      rowMeta_q   <= 4'b1111;
      rowSync_q   <= 4'b1111;
      hits_q      <= 2'd0;
      firstCode_q <= 4'h0;
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      cand_q      <= 4'h0;
      keyCode_q   <= 4'h0;
      keyValid_q  <= 1'b0;
      keyHeld_q   <= 1'b0;
    end else begin
      scanCnt_q   <= scanCnt_d;
      col_q       <= ~(4'b0001 << scanCnt_d[CW-1 -: 2]);
      rowMeta_q   <= row;
      rowSync_q   <= rowMeta_q;
      hits_q      <= hits_d;
      firstCode_q <= firstCode_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      keyCode_q   <= keyCode_d;
      keyValid_q  <= keyValid_d;
      keyHeld_q   <= keyHeld_d;
    end
  end

  assign col       = col_q;
  assign key_code  = keyCode_q;
  assign key_valid = keyValid_q;
  assign key_held  = keyHeld_q;

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Scoreboard bench for hex_keypad_scanner: a keypad model answers the column
// strobes, stimulus queues expected pulses, a monitor checks each key_valid.
module tb_hex_keypad_scanner;

  localparam int FRAME = 16;
  localparam int DS    = 3;

  // Key positions as bit index col*4+row
  localparam logic [15:0] K0 = 16'h0001 << 3;
  localparam logic [15:0] K1 = 16'h0001 << 0;
  localparam logic [15:0] K2 = 16'h0001 << 4;
  localparam logic [15:0] K5 = 16'h0001 << 5;
  localparam logic [15:0] KF = 16'h0001 << 7;
  localparam logic [15:0] K9 = 16'h0001 << 10;
  localparam logic [15:0] KA = 16'h0001 << 12;
  localparam logic [15:0] KD = 16'h0001 << 15;

  typedef struct {
    logic [3:0] code;
    int         when;
  } expect_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = '0;
  int          cyc;
  int          testsRun = 0;
  int          testsFailed = 0;
  expect_t     sbQ[$];
  expect_t     monEntry;

  hex_keypad_scanner #(.SCAN_BITS(2), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .row(row),
    .col(col),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col[c] && keys[c*4+r]) row[r] = 1'b0;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] mask, input int frames);
    keys = mask;
    repeat (FRAME * frames) @(posedge clk);
    @(negedge clk);
  endtask

  // Called on a frame boundary: a steady press is accepted after DS full frames.
  task automatic expectPress(input logic [3:0] code);
    sbQ.push_back('{code: code, when: cyc + DS * FRAME});
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && key_valid === 1'b1) begin
      if (sbQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected pulse: key_code %0h at cycle %0d, expected no pulse", key_code, cyc);
      end else begin
        monEntry = sbQ.pop_front();
        checkOutput("pulse code", 32'(key_code), 32'(monEntry.code));
        checkOutput("pulse cycle", 32'(cyc), 32'(monEntry.when));
        checkOutput("held at pulse", 32'(key_held), 32'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] expCol;

    repeat (3) @(negedge clk);
    checkOutput("reset col", 32'(col), 32'h0000_000E);
    checkOutput("reset key_code", 32'(key_code), 32'd0);
    checkOutput("reset key_valid", 32'(key_valid), 32'd0);
    checkOutput("reset key_held", 32'(key_held), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 2 * FRAME; i++) begin
      expCol = ~(4'b0001 << ((i / 4) % 4));
      checkOutput("col scan", 32'(col), 32'(expCol));
      @(posedge clk);
      @(negedge clk);
    end

    $display("[TB] press 5 and release");
    expectPress(4'h5);
    applyStimulus(K5, 4);
    checkOutput("5 held", 32'(key_held), 32'd1);
    applyStimulus('0, 2);
    checkOutput("5 held during release", 32'(key_held), 32'd1);
    applyStimulus('0, 1);
    checkOutput("5 released", 32'(key_held), 32'd0);

    $display("[TB] bouncing 9");
    applyStimulus(K9, 2);
    applyStimulus('0, 1);
    expectPress(4'h9);
    applyStimulus(K9, 4);
    applyStimulus('0, 4);
    checkOutput("9 released", 32'(key_held), 32'd0);

    $display("[TB] ghost 1+2");
    applyStimulus(K1 | K2, 6);
    checkOutput("ghost key_held", 32'(key_held), 32'd0);
    checkOutput("ghost key_code", 32'(key_code), 32'h9);
    applyStimulus('0, 1);

    $display("[TB] rollover D then A");
    expectPress(4'hD);
    applyStimulus(KD, 4);
    applyStimulus(KD | KA, 5);
    checkOutput("rollover key_code", 32'(key_code), 32'hD);
    checkOutput("rollover key_held", 32'(key_held), 32'd1);
    applyStimulus('0, 1);
    applyStimulus(KD, 1);
    checkOutput("release glitch held", 32'(key_held), 32'd1);
    applyStimulus('0, 3);
    checkOutput("D released", 32'(key_held), 32'd0);

    $display("[TB] corner keys 0 and F");
    expectPress(4'h0);
    applyStimulus(K0, 4);
    checkOutput("0 key_code", 32'(key_code), 32'h0);
    applyStimulus('0, 3);
    expectPress(4'hF);
    applyStimulus(KF, 4);
    checkOutput("F key_code", 32'(key_code), 32'hF);
    applyStimulus('0, 3);
    checkOutput("F released", 32'(key_held), 32'd0);

    $display("[TB] reset with a key held");
    expectPress(4'h5);
    applyStimulus(K5, 5);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midrun reset col", 32'(col), 32'h0000_000E);
    checkOutput("midrun reset key_code", 32'(key_code), 32'd0);
    checkOutput("midrun reset key_valid", 32'(key_valid), 32'd0);
    checkOutput("midrun reset key_held", 32'(key_held), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    expectPress(4'h5);
    applyStimulus(K5, 4);
    applyStimulus('0, 3);
    checkOutput("final released", 32'(key_held), 32'd0);

    checkOutput("scoreboard drained", 32'(sbQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
